// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues next_pc to instruction memory over req/ack, buffers
// returned words with their PCs in a 2-entry FIFO, and flushes on redirect.
module instr_fetch_unit #(
  parameter int unsigned OPD_WIDTH   = 32,
  parameter int unsigned PC_WIDTH    = 12,
  parameter int unsigned INSTR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_WIDTH-1:0]    fetch_pc,
  input  logic                   redirect,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [OPD_WIDTH-1:0]   instr_pc,
  output logic                   fetch_done
);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  state_e                 state_q;
  logic [PC_WIDTH-1:0]    req_pc_q;
  logic [INSTR_WIDTH-1:0] fifo_instr_q [2];
  logic [PC_WIDTH-1:0]    fifo_pc_q    [2];
  logic                   wr_ptr_q;
  logic                   rd_ptr_q;
  logic [1:0]             count_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic [PC_WIDTH-1:0]    instr_pc_q;
  logic                   fetch_done_q;

  logic                   room;
  logic                   head_valid;
  logic                   req_active;
  logic                   push;
  logic                   pop;
  logic [PC_WIDTH-1:0]    push_pc;
  logic                   rd_ptr_d;
  logic [1:0]             count_d;

  always_comb begin
    room       = count_q < 2'd2;
    head_valid = count_q != 2'd0;
    req_active = 1'b0;
    push       = 1'b0;
    imem_addr  = req_pc_q;
    push_pc    = req_pc_q;
    unique case (state_q)
      StIdle: begin
        req_active = room && !redirect;
        imem_addr  = fetch_pc;
        push_pc    = fetch_pc;
        push       = req_active && imem_ack;
      end
      StWait: begin
        req_active = 1'b1;
        push       = imem_ack && !redirect;
      end
      StDiscard: begin
        // Outstanding request must complete; its data is thrown away.
        req_active = 1'b1;
      end
      default: begin
        req_active = 1'b0;
      end
    endcase
    imem_req = req_active && !rst;
    pop      = head_valid && instr_ready && !redirect;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      req_pc_q     <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      instr_q      <= '0;
      instr_pc_q   <= '0;
      fetch_done_q <= 1'b0;
    end else begin
      fetch_done_q <= push;
      if (push) begin
        fifo_instr_q[wr_ptr_q] <= imem_rdata;
        fifo_pc_q[wr_ptr_q]    <= push_pc;
      end

      if (redirect) begin
        count_q  <= 2'd0;
        wr_ptr_q <= 1'b0;
        rd_ptr_q <= 1'b0;
      end else begin
        count_q  <= count_d;
        wr_ptr_q <= wr_ptr_q ^ push;
        rd_ptr_q <= rd_ptr_d;
        // Head output register tracks the next head; it holds when the FIFO empties.
        if (count_d != 2'd0) begin
          if (push && (rd_ptr_d == wr_ptr_q)) begin
            instr_q    <= imem_rdata;
            instr_pc_q <= push_pc;
          end else begin
            instr_q    <= fifo_instr_q[rd_ptr_d];
            instr_pc_q <= fifo_pc_q[rd_ptr_d];
          end
        end
      end

      unique case (state_q)
        StIdle: begin
          if (req_active) begin
            req_pc_q <= fetch_pc;
            if (!imem_ack) state_q <= StWait;
          end
        end
        StWait: begin
          if (imem_ack)      state_q <= StIdle;
          else if (redirect) state_q <= StDiscard;
        end
        StDiscard: begin
          if (imem_ack) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign instr_valid = head_valid && !rst;
  assign instr       = instr_q;
  assign instr_pc    = {{(OPD_WIDTH - PC_WIDTH){1'b0}}, instr_pc_q};
  assign fetch_done  = fetch_done_q && !rst;

endmodule
